// File: rtl/mc_control.sv
// mc_control: multicycle MIPS main control FSM with memory ready handshake.
// Define MC_CONTROL_PERF_EN to add instr_count/stall_count performance counters.
module mc_control #(
    parameter bit TRAP_HOLD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op,
    output logic [3:0] alu_cmd,
    output logic       trap,
    output logic [3:0] state_dbg
`ifdef MC_CONTROL_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [31:0] stall_count
`endif
);
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_RD    = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WR    = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;
    localparam logic [3:0] S_TRAP      = 4'd12;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    logic [3:0] state;
    logic [3:0] state_next;
    logic       act;
    logic       unused_zero;

    // zero is consumed by the datapath's PC-write gating, not by this FSM
    assign unused_zero = zero;
    assign act = !rst;

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (opcode)
                    OP_R:    state_next = S_R_EXEC;
                    OP_LW:   state_next = S_MEM_ADDR;
                    OP_SW:   state_next = S_MEM_ADDR;
                    OP_BEQ:  state_next = S_BRANCH;
                    OP_J:    state_next = S_JUMP;
                    OP_ADDI: state_next = S_ADDI_EXEC;
                    default: state_next = S_TRAP;
                endcase
            S_MEM_ADDR:  state_next = opcode == OP_SW ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:    state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_next = S_R_WB;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_TRAP:      state_next = TRAP_HOLD ? S_TRAP : S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= rst ? S_FETCH : state_next;
    end

    // outputs are forced to their idle values while rst is high
    always_comb begin
        pc_write      = act && (state == S_JUMP || (state == S_FETCH && mem_ready));
        pc_write_cond = act && state == S_BRANCH;
        pc_source     = !act ? 2'd0 : state == S_BRANCH ? 2'd1 : state == S_JUMP ? 2'd2 : 2'd0;
        i_or_d        = act && (state == S_MEM_RD || state == S_MEM_WR);
        mem_read      = act && (state == S_FETCH || state == S_MEM_RD);
        mem_write     = act && state == S_MEM_WR;
        ir_write      = act && state == S_FETCH && mem_ready;
        mem_to_reg    = act && state == S_MEM_WB;
        reg_dst       = act && state == S_R_WB;
        reg_write     = act && (state == S_MEM_WB || state == S_R_WB || state == S_ADDI_WB);
        alu_src_a     = act && (state == S_MEM_ADDR || state == S_R_EXEC ||
                                state == S_BRANCH || state == S_ADDI_EXEC);
        alu_src_b     = !act ? 2'd0 : state == S_FETCH ? 2'd1 : state == S_DECODE ? 2'd3 :
                        (state == S_MEM_ADDR || state == S_ADDI_EXEC) ? 2'd2 : 2'd0;
        alu_op        = act && state == S_R_EXEC;
        alu_cmd       = act && state == S_BRANCH ? ALU_SUB : ALU_ADD;
        trap          = act && state == S_TRAP;
        state_dbg     = act ? state : S_FETCH;
    end

`ifdef MC_CONTROL_PERF_EN
    logic retire;
    logic stall;

    assign retire = state_next == S_FETCH &&
                    state inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB};
    assign stall  = !mem_ready && state inside {S_FETCH, S_MEM_RD, S_MEM_WR};

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            instr_count <= instr_count + {31'd0, retire};
            stall_count <= stall_count + {31'd0, stall};
        end
    end
`endif
endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS processor. Sequences one instruction at a time through fetch, decode, execute, memory and writeback states, and drives the datapath's register and memory enables, mux selects and PC update. Drives the existing `alu_control` block through `alu_op`, and supplies a direct ALU command for non-R-type steps. Waits on a single shared instruction/data memory through a ready handshake.

## Interface
Parameters:
- `TRAP_HOLD`, default 1: when 1, the illegal-opcode state is sticky until reset. When 0, it returns to FETCH after one cycle.

Ports:
- `clk` input 1: single clock; rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: instruction register bits [31:26].
- `zero` input 1: ALU zero flag, used by `beq`.
- `mem_ready` input 1: memory has completed the current read or write this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if `zero`.
- `pc_source` output 2: PC mux select. 0 = ALU result, 1 = ALUOut register, 2 = jump target.
- `i_or_d` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: instruction register load.
- `mem_to_reg` output 1: writeback data select. 1 = MDR, 0 = ALUOut.
- `reg_dst` output 1: destination register select. 1 = rd, 0 = rt.
- `reg_write` output 1: register file write.
- `alu_src_a` output 1: ALU A select. 0 = PC, 1 = register A.
- `alu_src_b` output 2: ALU B select. 0 = register B, 1 = constant 4, 2 = sign-extended immediate, 3 = shifted sign-extended immediate.
- `alu_op` output 1: 1 = `alu_control` decodes funct. 0 = use `alu_cmd`.
- `alu_cmd` output 4: direct ALU control when `alu_op`=0. 4'b0010 = add, 4'b0110 = subtract.
- `trap` output 1: illegal opcode seen.
- `state_dbg` output 4: current state encoding.

## Operation
States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12.

Supported opcodes: R-type 000000, `lw` 100011, `sw` 101011, `beq` 000100, `j` 000010, `addi` 001000. Any other opcode in DECODE goes to TRAP.

Per-state behaviour (outputs not listed are 0):
- FETCH:
  - Asserts `mem_read`; `i_or_d`=0; `alu_src_a`=0; `alu_src_b`=1; `alu_cmd`=add; `pc_source`=0.
  - `ir_write` and `pc_write` are asserted only in the cycle where `mem_ready`=1.
  - Moves to DECODE when `mem_ready`=1; otherwise stays in FETCH.
- DECODE:
  - `alu_src_a`=0; `alu_src_b`=3; `alu_cmd`=add (computes the branch target).
  - Next state by opcode: R-type → R_EXEC, `lw`/`sw` → MEM_ADDR, `beq` → BRANCH, `j` → JUMP, `addi` → ADDI_EXEC, other → TRAP.
- MEM_ADDR: `alu_src_a`=1; `alu_src_b`=2; add. Next is MEM_RD for `lw`, MEM_WR for `sw`.
- MEM_RD: `mem_read`=1; `i_or_d`=1. Holds until `mem_ready`=1, then goes to MEM_WB.
- MEM_WB: `reg_write`=1; `mem_to_reg`=1; `reg_dst`=0. Next is FETCH.
- MEM_WR: `mem_write`=1; `i_or_d`=1. Holds until `mem_ready`=1, then goes to FETCH.
- R_EXEC: `alu_src_a`=1; `alu_src_b`=0; `alu_op`=1. Next is R_WB.
- R_WB: `reg_write`=1; `reg_dst`=1; `mem_to_reg`=0. Next is FETCH.
- BRANCH: `alu_src_a`=1; `alu_src_b`=0; `alu_cmd`=subtract; `pc_write_cond`=1; `pc_source`=1. Next is FETCH.
- JUMP: `pc_write`=1; `pc_source`=2. Next is FETCH.
- ADDI_EXEC: `alu_src_a`=1; `alu_src_b`=2; add. Next is ADDI_WB.
- ADDI_WB: `reg_write`=1; `reg_dst`=0; `mem_to_reg`=0. Next is FETCH.
- TRAP: `trap`=1; all enables 0. With `TRAP_HOLD`=1 it stays in TRAP; with 0 it goes to FETCH.

## Timing
- Outputs are Moore, decoded from the state register. The exceptions are `ir_write` and `pc_write` in FETCH, which are gated combinationally by `mem_ready`.
- Reset: `rst` high at a rising edge forces FETCH. During and after reset, all enables are 0, `alu_cmd`=4'b0010, `trap`=0 and `state_dbg`=0.
  - FETCH-state `mem_read`=1 appears in the first cycle after reset deasserts.
  - Reset wins over any transition, including mid-MEM_RD and mid-MEM_WR.
- Latency with `mem_ready` held at 1:
  - `lw`: 5 cycles.
  - `sw`, R-type, `addi`: 4 cycles.
  - `beq`, `j`: 3 cycles.
- Every cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_read` and `mem_write` are never both 1. The request stays stable until the cycle `mem_ready`=1.
- `mem_ready` is ignored in all states other than FETCH, MEM_RD and MEM_WR.
- `opcode` is sampled only in DECODE and MEM_ADDR. The IR holds it stable in those states.

## Configuration
- `MC_CONTROL_PERF_EN` defined: adds two output ports.
  - `instr_count` (32 bits): increments on each transition into FETCH from a writeback, branch, jump or MEM_WR state.
  - `stall_count` (32 bits): increments on each cycle in a memory state with `mem_ready`=0.
  - Both clear on `rst` and wrap modulo 2^32.
- `MC_CONTROL_PERF_EN` undefined: neither counter nor port exists; all other behaviour is identical.

## Test plan
- Reset then release, `mem_ready`=1, opcode 000000: `state_dbg` goes 0,1,6,7,0. `alu_op`=1 only in state 6; `reg_write`=1 and `reg_dst`=1 only in state 7.
- `lw` with `mem_ready` low for 2 cycles in MEM_RD: 7 cycles total, `mem_read` and `i_or_d`=1 held across the stall. With PERF_EN, `stall_count`=2 and `instr_count`=1.
- `beq` with `zero`=1: in BRANCH, `pc_write_cond`=1, `alu_cmd`=4'b0110, `pc_source`=1; next state FETCH.
- Opcode 111111 in DECODE: TRAP, `trap`=1 held for 10 cycles. `rst` pulse then gives `trap`=0 and state FETCH.
- `rst` asserted in MEM_WR while `mem_ready`=0: next cycle is FETCH with `mem_write`=0.
- FETCH with `mem_ready`=0 for 3 cycles: `ir_write` and `pc_write` stay 0, then pulse for exactly one cycle when `mem_ready` rises.
